// File: rtl/multicycle_controller.sv
// multicycle_controller: RV32I multicycle sequencer; decodes op/funct3/funct7b5/zero into PC, memory, register-file, mux-select and ALU-control lines
module multicycle_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       illegal_op
);
    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
        EXECR, EXECI, ALUWB, BEQ, JAL
    } state_t;
    localparam logic [6:0] OP_LW = 7'b0000011, OP_SW = 7'b0100011, OP_R = 7'b0110011,
                           OP_I = 7'b0010011, OP_BEQ = 7'b1100011, OP_JAL = 7'b1101111;
    localparam logic [1:0] ALU_ADD = 2'b00, ALU_SUB = 2'b01, ALU_FUNCT = 2'b10;
    state_t state, next;
    logic [1:0] alu_op;
    always_ff @(posedge clk or posedge reset)
        if (reset) state <= FETCH;
        else       state <= next;
    always_comb begin
        next = FETCH;
        case (state)
            FETCH:  next = DECODE;
            DECODE: next = (op == OP_LW || op == OP_SW) ? MEMADR :
                           (op == OP_R)   ? EXECR :
                           (op == OP_I)   ? EXECI :
                           (op == OP_BEQ) ? BEQ :
                           (op == OP_JAL) ? JAL : FETCH;
            MEMADR:  next = (op == OP_LW) ? MEMREAD : MEMWRITE;
            MEMREAD: next = MEMWB;
            EXECR:   next = ALUWB;
            EXECI:   next = ALUWB;
            JAL:     next = ALUWB;
            default: next = FETCH;
        endcase
    end
    always_comb begin
        PCWrite    = 1'b0;
        AdrSrc     = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        MemWrite   = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        alu_op     = ALU_ADD;
        illegal_op = 1'b0;
        case (state)
            FETCH: begin
                IRWrite   = 1'b1;
                PCWrite   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            DECODE: begin
                ALUSrcA    = 2'b01;
                ALUSrcB    = 2'b01;
                illegal_op = !(op inside {OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL});
            end
            MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            MEMREAD: AdrSrc = 1'b1;
            MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
            end
            MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
            end
            EXECR: begin
                ALUSrcA = 2'b10;
                alu_op  = ALU_FUNCT;
            end
            EXECI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                alu_op  = ALU_FUNCT;
            end
            ALUWB: RegWrite = 1'b1;
            BEQ: begin
                ALUSrcA = 2'b10;
                alu_op  = ALU_SUB;
                PCWrite = zero;
            end
            JAL: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                PCWrite = 1'b1;
            end
            default: ;
        endcase
    end
    always_comb begin
        ImmSrc = (op == OP_SW) ? 2'b01 : (op == OP_BEQ) ? 2'b10 : (op == OP_JAL) ? 2'b11 : 2'b00;
        ALUControl = (alu_op == ALU_SUB) ? 3'b001 :
                     (alu_op != ALU_FUNCT) ? 3'b000 :
                     (funct3 == 3'b000) ? ((op[5] & funct7b5) ? 3'b001 : 3'b000) :
                     (funct3 == 3'b010) ? 3'b101 :
                     (funct3 == 3'b110) ? 3'b011 :
                     (funct3 == 3'b111) ? 3'b010 : 3'b000;
    end
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: scoreboard bench comparing per-cycle control vectors against a per-instruction reference model
module tb_multicycle_controller;
    logic clk = 1'b0, reset = 1'b1, funct7b5 = 1'b0, zero = 1'b0;
    logic [6:0] op = 7'b0;
    logic [2:0] funct3 = 3'b0;
    logic PCWrite, AdrSrc, IRWrite, RegWrite, MemWrite, illegal_op;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;
    logic [16:0] got;
    typedef struct { logic [16:0] v; int ins; int cyc; } exp_t;
    exp_t q[$];
    int compared = 0, mismatched = 0, ins_no = 0;
    multicycle_controller dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .IRWrite(IRWrite), .RegWrite(RegWrite),
        .MemWrite(MemWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ImmSrc(ImmSrc), .ALUControl(ALUControl), .illegal_op(illegal_op)
    );
    always #5 clk = ~clk;
    assign got = {PCWrite, AdrSrc, IRWrite, RegWrite, MemWrite, ResultSrc, ALUSrcA, ALUSrcB,
                  ImmSrc, ALUControl, illegal_op};
    function automatic logic [16:0] mk(input logic pcw, adr, irw, rw, mw, input logic [1:0] rs, sa, sb,
                                       input logic [6:0] o, input logic [2:0] alu, input logic ill);
        logic [1:0] imm;
        imm = (o == 7'b0100011) ? 2'b01 : (o == 7'b1100011) ? 2'b10 : (o == 7'b1101111) ? 2'b11 : 2'b00;
        return {pcw, adr, irw, rw, mw, rs, sa, sb, imm, alu, ill};
    endfunction
    function automatic logic [2:0] funct_alu(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        case (f3)
            3'b000:  return (o == 7'b0110011 && f7) ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction
    task automatic push(input logic [16:0] v, input int c);
        exp_t e;
        e.v = v; e.ins = ins_no; e.cyc = c;
        q.push_back(e);
    endtask
    // Called just after a rising edge with the DUT in FETCH; returns in the same position.
    task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic z);
        logic [16:0] seq[$];
        logic [16:0] fetch_v, memadr_v, aluwb_v;
        logic legal;
        op = o; funct3 = f3; funct7b5 = f7; zero = z;
        legal = o inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111};
        fetch_v  = mk(1, 0, 1, 0, 0, 2'b10, 2'b00, 2'b10, o, 3'b000, 0);
        memadr_v = mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, o, 3'b000, 0);
        aluwb_v  = mk(0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, o, 3'b000, 0);
        seq.push_back(fetch_v);
        seq.push_back(mk(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, o, 3'b000, !legal));
        case (o)
            7'b0000011: begin
                seq.push_back(memadr_v);
                seq.push_back(mk(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, o, 3'b000, 0));
                seq.push_back(mk(0, 0, 0, 1, 0, 2'b01, 2'b00, 2'b00, o, 3'b000, 0));
            end
            7'b0100011: begin
                seq.push_back(memadr_v);
                seq.push_back(mk(0, 1, 0, 0, 1, 2'b00, 2'b00, 2'b00, o, 3'b000, 0));
            end
            7'b0110011: begin
                seq.push_back(mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, o, funct_alu(o, f3, f7), 0));
                seq.push_back(aluwb_v);
            end
            7'b0010011: begin
                seq.push_back(mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, o, funct_alu(o, f3, f7), 0));
                seq.push_back(aluwb_v);
            end
            7'b1100011: seq.push_back(mk(z, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, o, 3'b001, 0));
            7'b1101111: begin
                seq.push_back(mk(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, o, 3'b000, 0));
                seq.push_back(aluwb_v);
            end
            default: ;
        endcase
        foreach (seq[i]) push(seq[i], i);
        repeat (seq.size()) @(posedge clk);
        #1;
        ins_no++;
    endtask
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                e = q.pop_front();
                compared++;
                if (got !== e.v) begin
                    mismatched++;
                    $display("FAIL ctl ins%0d cyc%0d got=%b exp=%b", e.ins, e.cyc, got, e.v);
                end
            end
        end
    end
    initial begin
        logic [6:0] ops[7];
        logic [6:0] o;
        ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111, 7'b0000000};
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        run_instr(7'b0000011, 3'b010, 1'b0, 1'b0);
        run_instr(7'b0100011, 3'b010, 1'b0, 1'b0);
        run_instr(7'b0110011, 3'b000, 1'b1, 1'b0);
        run_instr(7'b0110011, 3'b000, 1'b0, 1'b0);
        run_instr(7'b0010011, 3'b000, 1'b1, 1'b0);
        run_instr(7'b0110011, 3'b010, 1'b0, 1'b0);
        run_instr(7'b0010011, 3'b110, 1'b0, 1'b0);
        run_instr(7'b0110011, 3'b111, 1'b0, 1'b0);
        run_instr(7'b0110011, 3'b001, 1'b0, 1'b0);
        run_instr(7'b1100011, 3'b000, 1'b0, 1'b1);
        run_instr(7'b1100011, 3'b000, 1'b0, 1'b0);
        run_instr(7'b1101111, 3'b000, 1'b0, 1'b0);
        run_instr(7'b0000000, 3'b000, 1'b0, 1'b0);
        run_instr(7'b1111111, 3'b000, 1'b0, 1'b0);
        // Abandon an R-type in EXECR with an asynchronous reset.
        op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b1;
        push(mk(1, 0, 1, 0, 0, 2'b10, 2'b00, 2'b10, op, 3'b000, 0), 0);
        push(mk(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, op, 3'b000, 0), 1);
        push(mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, op, 3'b001, 0), 2);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2 reset = 1'b1;
        #1 compared++;
        if (got !== mk(1, 0, 1, 0, 0, 2'b10, 2'b00, 2'b10, op, 3'b000, 0)) begin
            mismatched++;
            $display("FAIL async_reset got=%b", got);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        ins_no++;
        for (int n = 0; n < 300; n++) begin
            o = ops[$urandom_range(0, 6)];
            if (o == 7'b0000000) begin
                o = 7'($urandom);
                while (o inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111})
                    o = 7'($urandom);
            end
            run_instr(o, 3'($urandom), 1'($urandom), 1'($urandom));
        end
        @(negedge clk);
        #1 compared++;
        if (q.size() != 0) begin
            mismatched++;
            $display("FAIL drain left=%0d exp=0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Sequencing controller for the multicycle RV32I datapath. It decodes the latched instruction fields and the ALU zero flag, and each cycle drives the datapath select, enable and ALU-operation lines. It supports lw, sw, R-type, I-type ALU, beq and jal. The block sits beside the datapath in the processor top level and is the sole source of its control inputs plus the memory write enable.

## Interface
Parameters: none.

Ports:
- clk  in  1  processor clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high; forces FETCH immediately
- op  in  7  Instr[6:0]
- funct3  in  3  Instr[14:12]
- funct7b5  in  1  Instr[30]
- zero  in  1  ALU zero flag from the datapath
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address select: 0 = PC, 1 = Result
- IRWrite  out  1  instruction and OldPC register enable
- RegWrite  out  1  register file write enable
- MemWrite  out  1  data memory write enable
- ResultSrc  out  2  00 = ALUOut, 01 = Data, 10 = ALURes
- ALUSrcA  out  2  00 = PC, 01 = OldPC, 10 = A
- ALUSrcB  out  2  00 = WriteData, 01 = ImmExt, 10 = constant 4
- ImmSrc  out  2  00 = I, 01 = S, 10 = B, 11 = J
- ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- illegal_op  out  1  one-cycle pulse in DECODE when the opcode is unsupported

## Operation
- The main FSM is Moore, with one exception: PCWrite in BEQ also depends on zero. The encoded state register is internal.
- All outputs are 0 unless the state row below says otherwise. ImmSrc is a pure function of op at all times:
  - lw / I-ALU: 00
  - sw: 01
  - beq: 10
  - jal: 11
  - other opcodes: 00
- States and what each one drives:
  - FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=add, ResultSrc=10, PCWrite=1. Next state is DECODE.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=add (branch target into ALUOut).
  - Transitions out of DECODE by op:
    - 0000011 or 0100011 → MEMADR
    - 0110011 → EXECR
    - 0010011 → EXECI
    - 1100011 → BEQ
    - 1101111 → JAL
    - anything else → FETCH, with illegal_op=1 in that DECODE cycle
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=add. Next is MEMREAD if op=0000011, else MEMWRITE.
  - MEMREAD: ResultSrc=00, AdrSrc=1. Next is MEMWB.
  - MEMWB: ResultSrc=01, RegWrite=1. Next is FETCH.
  - MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1. Next is FETCH.
  - EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=funct. Next is ALUWB.
  - EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=funct. Next is ALUWB.
  - ALUWB: ResultSrc=00, RegWrite=1. Next is FETCH.
  - BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=sub, ResultSrc=00, PCWrite=zero. Next is FETCH.
  - JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=add, ResultSrc=00, PCWrite=1. Next is ALUWB.
- ALU decoder (combinational):
  - ALUOp add → 000
  - ALUOp sub → 001
  - ALUOp funct, selected by funct3:
    - 000: sub (001) if op[5] & funct7b5, else add (000)
    - 010: slt (101)
    - 110: or (011)
    - 111: and (010)
    - any other funct3: add (000)

## Timing
- Reset is asynchronous. When reset asserts, the state goes to FETCH within the same cycle, with no clock edge needed. Outputs then take the FETCH values: IRWrite=1, PCWrite=1, ALUSrcB=10, ResultSrc=10, all others 0, illegal_op=0.
- The first fetch edge is the first rising edge after reset deasserts.
- Reset mid-instruction abandons that instruction. MemWrite and RegWrite drop combinationally with the state.
- Cycles per instruction, counted from FETCH inclusive:
  - lw 5
  - sw 4
  - R-type 4
  - I-ALU 4
  - beq 3
  - jal 4
  - illegal 2
- op, funct3 and funct7b5 are sampled only in DECODE, MEMADR and the ALU decoder. They are stable from the instruction register after FETCH.
- In BEQ, zero must settle within the cycle; PCWrite follows it combinationally.
- No state is held longer than one cycle, and there are no stalls.

## Test plan
- Reset during EXECR with op=0110011 → state is FETCH without a clock edge; RegWrite=0, IRWrite=1, PCWrite=1, ALUControl=000.
- lw, op=0000011 → 5-cycle sequence FETCH, DECODE, MEMADR, MEMREAD, MEMWB. Exactly one RegWrite pulse, with ResultSrc=01 in that cycle; AdrSrc=1 in MEMREAD.
- sw, op=0100011 → 4 cycles with MemWrite=1 only in cycle 4; ImmSrc=01 throughout; RegWrite never asserts.
- R-type sub (funct3=000, funct7b5=1) gives ALUControl=001 in EXECR. addi (op=0010011, funct3=000, funct7b5=1) gives 000 in EXECI. funct3=010 gives 101, 110 gives 011, 111 gives 010.
- beq, op=1100011:
  - zero=1 in cycle 3 → PCWrite=1, ResultSrc=00, ALUControl=001
  - zero=0 → PCWrite=0
  - both cases return to FETCH
- jal, op=1101111 → JAL cycle with ALUSrcA=01, ALUSrcB=10, PCWrite=1; then ALUWB with RegWrite=1. An unsupported op such as 0000000 → illegal_op=1 for the one DECODE cycle, then FETCH.
